// File: rtl/ovm_seq_arbiter_if.sv
// Purpose: bundles the requester bus and the driver offer channel of ovm_seq_arbiter.
// Ports: req/req_pri/req_data/mode come from the requesters; grant, item_* and busy go out.
// Modports: slave = arbiter side, master = requester/driver side.
interface ovm_seq_arbiter_if #(
  parameter int NREQ = 4,
  parameter int DW   = 32,
  parameter int PW   = 4
);
  localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;

  logic [NREQ-1:0]    req;
  logic [NREQ*PW-1:0] req_pri;
  logic [NREQ*DW-1:0] req_data;
  logic [1:0]         mode;
  logic [NREQ-1:0]    grant;
  logic               item_valid;
  logic               item_ready;
  logic [DW-1:0]      item_data;
  logic [IW-1:0]      item_id;
  logic               item_done;
  logic               busy;

  modport slave (
    input  req, req_pri, req_data, mode, item_ready, item_done,
    output grant, item_valid, item_data, item_id, busy
  );

  modport master (
    output req, req_pri, req_data, mode, item_ready, item_done,
    input  grant, item_valid, item_data, item_id, busy
  );
endinterface

// File: rtl/ovm_seq_arbiter.sv
// Purpose: sequencer arbiter; picks one pending requester (FIFO age / strict priority / round robin) and offers its item.
// Latency: grant, item_valid, item_data and item_id are registered one edge after req is sampled in IDLE.
// Backpressure: the offer holds until item_ready; no new arbitration happens until item_done returns the FSM to IDLE.
// Ports: clk, rst_n (async active-low); bus.slave carries req/req_pri/req_data/mode in and grant/item_*/busy out.
module ovm_seq_arbiter #(
  parameter int NREQ = 4,
  parameter int DW   = 32,
  parameter int PW   = 4
) (
  input logic                clk,
  input logic                rst_n,
  ovm_seq_arbiter_if.slave   bus
);
  localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int KW = PW + 8;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_OFFER = 2'd1;
  localparam logic [1:0] S_BUSY  = 2'd2;

  logic [1:0]      state_q, state_d;
  logic [NREQ-1:0] grant_q, grant_d;
  logic [NREQ-1:0] req_prev_q;
  logic            item_valid_q, item_valid_d;
  logic [DW-1:0]   item_data_q, item_data_d;
  logic [IW-1:0]   item_id_q, item_id_d;
  logic [IW-1:0]   last_grant_q, last_grant_d;
  logic [7:0]      age_q   [NREQ];
  logic [7:0]      age_d   [NREQ];
  logic [7:0]      age_eff [NREQ];

  logic [NREQ-1:0] req_rise;
  logic [NREQ-1:0] elig;
  logic            win_vld;
  logic [IW-1:0]   win_idx;
  logic [KW-1:0]   best_key;

  assign req_rise = bus.req & ~req_prev_q;
  // The requester granted last edge may still show req this cycle; keep it out.
  assign elig     = bus.req & ~grant_q;

  // A freshly raised request counts as age 0 even before its counter clears,
  // otherwise a stale count from an earlier request would leak into arbitration.
  always_comb begin
    for (int i = 0; i < NREQ; i++) begin
      age_eff[i] = req_rise[i] ? 8'd0 : age_q[i];
    end
  end

  // Priority/age search: strict mode prepends priority to the age so one
  // compare covers both; strict '>' keeps the lowest index on ties.
  always_comb begin
    logic [KW-1:0] key;
    int            idx;
    win_vld  = 1'b0;
    win_idx  = '0;
    best_key = '0;
    key      = '0;
    idx      = 0;
    for (int i = 0; i < NREQ; i++) begin
      key = {(bus.mode == 2'd1) ? bus.req_pri[i*PW +: PW] : {PW{1'b0}}, age_eff[i]};
      if (elig[i] && (!win_vld || key > best_key)) begin
        win_vld  = 1'b1;
        win_idx  = IW'(i);
        best_key = key;
      end
    end
    if (bus.mode == 2'd2) begin
      win_vld = 1'b0;
      win_idx = '0;
      // Walk from farthest to nearest so the first pending index after
      // last_grant is the one left standing.
      for (int k = NREQ; k >= 1; k--) begin
        idx = (int'(last_grant_q) + k) % NREQ;
        if (elig[idx]) begin
          win_vld = 1'b1;
          win_idx = IW'(idx);
        end
      end
    end
  end

  always_comb begin
    state_d      = state_q;
    grant_d      = '0;
    item_valid_d = item_valid_q;
    item_data_d  = item_data_q;
    item_id_d    = item_id_q;
    last_grant_d = last_grant_q;
    case (state_q)
      S_IDLE: begin
        if (win_vld) begin
          grant_d[win_idx] = 1'b1;
          item_valid_d     = 1'b1;
          item_data_d      = bus.req_data[int'(win_idx)*DW +: DW];
          item_id_d        = win_idx;
          last_grant_d     = win_idx;
          state_d          = S_OFFER;
        end
      end
      S_OFFER: begin
        if (bus.item_ready) begin
          item_valid_d = 1'b0;
          if (bus.item_done) begin
            state_d     = S_IDLE;
            item_data_d = '0;
            item_id_d   = '0;
          end else begin
            state_d = S_BUSY;
          end
        end
      end
      S_BUSY: begin
        if (bus.item_done) begin
          state_d     = S_IDLE;
          item_data_d = '0;
          item_id_d   = '0;
        end
      end
      default: begin
        state_d      = S_IDLE;
        item_valid_d = 1'b0;
        item_data_d  = '0;
        item_id_d    = '0;
      end
    endcase
  end

  always_comb begin
    for (int i = 0; i < NREQ; i++) begin
      age_d[i] = age_eff[i];
      if (!req_rise[i] && bus.req[i] && !grant_d[i] && !grant_q[i] && age_q[i] != 8'hFF) begin
        age_d[i] = age_q[i] + 8'd1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      grant_q      <= '0;
      req_prev_q   <= '0;
      item_valid_q <= 1'b0;
      item_data_q  <= '0;
      item_id_q    <= '0;
      last_grant_q <= IW'(NREQ - 1);
      for (int i = 0; i < NREQ; i++) begin
        age_q[i] <= 8'd0;
      end
    end else begin
      state_q      <= state_d;
      grant_q      <= grant_d;
      req_prev_q   <= bus.req;
      item_valid_q <= item_valid_d;
      item_data_q  <= item_data_d;
      item_id_q    <= item_id_d;
      last_grant_q <= last_grant_d;
      for (int i = 0; i < NREQ; i++) begin
        age_q[i] <= age_d[i];
      end
    end
  end

  assign bus.grant      = grant_q;
  assign bus.item_valid = item_valid_q;
  assign bus.item_data  = item_data_q;
  assign bus.item_id    = item_id_q;
  assign bus.busy       = (state_q != S_IDLE);
endmodule

// File: tb/tb_ovm_seq_arbiter.sv
// Purpose: directed bench for ovm_seq_arbiter (NREQ=4, DW=32, PW=4).
// Latency: one table of single-arbitration vectors plus hand-written multi-cycle sequences.
// Backpressure: the bench plays both requesters and driver, holding item_ready low where a stall is wanted.
module tb_ovm_seq_arbiter;
  logic clk = 1'b0;
  logic rst_n;
  int   checks = 0;
  int   failures = 0;

  ovm_seq_arbiter_if #(.NREQ(4), .DW(32), .PW(4)) bus ();

  ovm_seq_arbiter #(.NREQ(4), .DW(32), .PW(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]  mode;
    logic [3:0]  req;
    logic [15:0] pri;
    logic [3:0]  exp_grant;
    logic [1:0]  exp_id;
    logic [31:0] exp_data;
  } vec_t;

  vec_t vecs [8];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_grant(input string name, input int exp_idx);
    bit seen = 1'b0;
    logic [3:0] one;
    one = 4'b0001 << exp_idx;
    for (int c = 0; c < 8 && !seen; c++) begin
      step();
      if (bus.grant != 4'b0000) seen = 1'b1;
    end
    if (!seen) begin
      chk({name, "_timeout"}, 64'(0), 64'(1));
    end else begin
      chk({name, "_grant"}, 64'(bus.grant), 64'(one));
      chk({name, "_id"}, 64'(bus.item_id), 64'(exp_idx));
      chk({name, "_data"}, 64'(bus.item_data), 64'(32'hDA7A0000 + exp_idx));
      chk({name, "_valid"}, 64'(bus.item_valid), 64'(1));
    end
  endtask

  task automatic complete_item(input string name);
    bus.item_ready = 1'b1;
    bus.item_done  = 1'b1;
    step();
    bus.item_ready = 1'b0;
    bus.item_done  = 1'b0;
    chk({name, "_idle"}, 64'(bus.busy), 64'(0));
  endtask

  task automatic do_reset();
    bus.req = '0; bus.item_ready = 1'b0; bus.item_done = 1'b0;
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    step();
  endtask

  initial begin
    int bad;
    vecs[0] = '{2'd0, 4'b0110, 16'h0000, 4'b0010, 2'd1, 32'hDA7A0001};
    vecs[1] = '{2'd3, 4'b1001, 16'h0000, 4'b0001, 2'd0, 32'hDA7A0000};
    vecs[2] = '{2'd1, 4'b1111, 16'h1772, 4'b0010, 2'd1, 32'hDA7A0001};
    vecs[3] = '{2'd1, 4'b1100, 16'h5400, 4'b1000, 2'd3, 32'hDA7A0003};
    vecs[4] = '{2'd2, 4'b1111, 16'h0000, 4'b0001, 2'd0, 32'hDA7A0000};
    vecs[5] = '{2'd2, 4'b1010, 16'h0000, 4'b0010, 2'd1, 32'hDA7A0001};
    vecs[6] = '{2'd2, 4'b0001, 16'h0000, 4'b0001, 2'd0, 32'hDA7A0000};
    vecs[7] = '{2'd2, 4'b1100, 16'h0000, 4'b0100, 2'd2, 32'hDA7A0002};

    bus.req = '0; bus.req_pri = '0; bus.mode = 2'd0;
    bus.item_ready = 1'b0; bus.item_done = 1'b0;
    bus.req_data = {32'hDA7A0003, 32'hDA7A0002, 32'hDA7A0001, 32'hDA7A0000};
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_grant", 64'(bus.grant), 64'(0));
    chk("rst_valid", 64'(bus.item_valid), 64'(0));
    chk("rst_data", 64'(bus.item_data), 64'(0));
    chk("rst_id", 64'(bus.item_id), 64'(0));
    chk("rst_busy", 64'(bus.busy), 64'(0));
    rst_n = 1'b1;
    step();

    // Single-arbitration table; round-robin rows rely on last_grant from the rows above.
    for (int v = 0; v < 8; v++) begin
      bus.mode    = vecs[v].mode;
      bus.req_pri = vecs[v].pri;
      bus.req     = vecs[v].req;
      step();
      chk($sformatf("vec%0d_grant", v), 64'(bus.grant), 64'(vecs[v].exp_grant));
      chk($sformatf("vec%0d_id", v), 64'(bus.item_id), 64'(vecs[v].exp_id));
      chk($sformatf("vec%0d_data", v), 64'(bus.item_data), 64'(vecs[v].exp_data));
      chk($sformatf("vec%0d_valid", v), 64'(bus.item_valid), 64'(1));
      chk($sformatf("vec%0d_busy", v), 64'(bus.busy), 64'(1));
      bus.req = '0;
      complete_item($sformatf("vec%0d", v));
    end

    // FIFO: req[2] first, req[0] raised during a long stall, served after.
    bus.mode = 2'd0;
    bus.req  = 4'b0100;
    expect_grant("fifo_first", 2);
    bus.req = 4'b0000;
    bad = 0;
    for (int c = 1; c < 10; c++) begin
      if (c == 3) bus.req = 4'b0001;
      step();
      if (!(bus.item_valid && bus.item_id == 2'd2 && bus.grant == 4'b0000)) bad++;
    end
    chk("fifo_stall_hold", 64'(bad), 64'(0));
    bus.item_ready = 1'b1;
    step();
    chk("fifo_accept_valid", 64'(bus.item_valid), 64'(0));
    chk("fifo_accept_busy", 64'(bus.busy), 64'(1));
    bus.item_ready = 1'b0;
    bus.item_done  = 1'b1;
    step();
    bus.item_done = 1'b0;
    chk("fifo_done_idle", 64'(bus.busy), 64'(0));
    chk("fifo_done_nogrant", 64'(bus.grant), 64'(0));
    expect_grant("fifo_second", 0);
    bus.req = 4'b0000;
    complete_item("fifo_second");

    // Handshake: stalled offer ignores item_done and stays stable.
    bus.req = 4'b1000;
    expect_grant("hs", 3);
    bus.req = 4'b0000;
    bad = 0;
    for (int c = 0; c < 5; c++) begin
      bus.item_done = c[0];
      if (c == 2) bus.mode = 2'd2;
      step();
      if (!(bus.item_valid && bus.item_data == 32'hDA7A0003 && bus.item_id == 2'd3
            && bus.busy && bus.grant == 4'b0000)) bad++;
    end
    bus.item_done = 1'b0;
    chk("hs_stall_stable", 64'(bad), 64'(0));
    complete_item("hs_ready_done");
    chk("hs_valid_low", 64'(bus.item_valid), 64'(0));

    // Strict: requesters queue up behind a stalled item, then drain by priority/age.
    bus.mode    = 2'd1;
    bus.req_pri = 16'h9039;
    bus.req     = 4'b0100;
    expect_grant("strict_setup", 2);
    bus.req = 4'b0001;
    step(); step();
    bus.req = 4'b1011;
    step(); step();
    complete_item("strict_setup");
    expect_grant("strict_1", 0);
    bus.req = 4'b1010;
    complete_item("strict_1");
    expect_grant("strict_2", 3);
    bus.req = 4'b0010;
    complete_item("strict_2");
    expect_grant("strict_3", 1);
    bus.req = 4'b0000;
    complete_item("strict_3");

    // Round robin from reset: 0,1,2,3,0 with re-raised requests.
    do_reset();
    bus.mode = 2'd2;
    bus.req = 4'b1111;
    bus.item_ready = 1'b1;
    for (int g = 0; g < 5; g++) begin
      expect_grant($sformatf("rr_%0d", g), g % 4);
      bus.req[g % 4] = 1'b0;
      step();
      chk($sformatf("rr_%0d_pulse", g), 64'(bus.grant), 64'(0));
      bus.item_done = 1'b1;
      bus.req[g % 4] = 1'b1;
      step();
      bus.item_done = 1'b0;
    end
    bus.req = 4'b0000;
    bus.item_ready = 1'b0;
    step();

    // Reset asserted while BUSY clears outputs without a clock edge.
    bus.mode = 2'd0;
    bus.req  = 4'b0100;
    expect_grant("rstb_setup", 2);
    bus.req = 4'b0000;
    bus.item_ready = 1'b1;
    step();
    bus.item_ready = 1'b0;
    chk("rstb_busy", 64'(bus.busy), 64'(1));
    chk("rstb_id", 64'(bus.item_id), 64'(2));
    #3;
    rst_n = 1'b0;
    #1;
    chk("rstb_async_busy", 64'(bus.busy), 64'(0));
    chk("rstb_async_id", 64'(bus.item_id), 64'(0));
    chk("rstb_async_other", 64'({bus.grant, bus.item_valid, bus.item_data}), 64'(0));
    #2;
    rst_n = 1'b1;
    bad = 0;
    for (int c = 0; c < 6; c++) begin
      step();
      if (bus.grant != 4'b0000 || bus.busy || bus.item_valid) bad++;
    end
    chk("rstb_quiet_after", 64'(bad), 64'(0));

    // Age saturation: req[1] waits behind a long stall and beats a fresh req[0].
    bus.mode = 2'd0;
    bus.req  = 4'b0001;
    expect_grant("age_setup", 0);
    bus.req = 4'b0010;
    repeat (300) step();
    chk("age_sat_value", 64'(dut.age_q[1]), 64'(255));
    chk("age_still_busy", 64'(bus.busy), 64'(1));
    bus.req = 4'b0011;
    complete_item("age_setup");
    expect_grant("age_winner", 1);
    bus.req = 4'b0001;
    complete_item("age_winner");
    expect_grant("age_after", 0);
    bus.req = 4'b0000;
    complete_item("age_after");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
